// File: rtl/gen_fifo_rd_status_pkg.sv
// ----------------------------------------------------------------------------
// gen_fifo_rd_status_pkg
// Shared helpers for the async FIFO pointer logic. The read-side status block
// and the write-side full-flag block both use these.
//   ptr_width() : pointer width for a given address width (one extra wrap bit)
//   gray2bin()  : gray to binary conversion, width-agnostic (see below)
//   bin2gray()  : binary to gray conversion, width-agnostic
// ----------------------------------------------------------------------------
package gen_fifo_rd_status_pkg;

    // Widest pointer the helpers handle. Narrower pointers are zero-extended
    // on the way in and truncated on the way out. Zero bits above the MSB do
    // not change the XOR prefix, so the result is exact for any width.
    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Binary bit i is the XOR of gray bits [MSB:i].
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gen_fifo_rd_status_ptr_sync.sv
// ----------------------------------------------------------------------------
// gen_ptr_sync
// Multi-bit flop-chain synchroniser for a gray-coded pointer. Only a gray
// vector may pass through here: at most one bit changes per source update,
// so the sampled value is always either the old or the new pointer.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset (all stages cleared)
//   d       : gray pointer from the foreign clock domain
//   q       : synchronised gray pointer (last stage)
// ----------------------------------------------------------------------------
module gen_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gen_fifo_rd_status.sv
// ----------------------------------------------------------------------------
// gen_fifo_rd_status
// Read-domain status stage of the async FIFO, downstream of the read-side
// gray pointer counter. Synchronises the write pointer, derives empty /
// almost_empty / fill level, gates pops, and supplies the flush load value.
//   clk           : read-domain clock
//   reset_n       : asynchronous active-low reset
//   wr_ptr_gray   : write pointer (gray), asynchronous to clk
//   rd_ptr_gray   : local read pointer (gray) from the read counter
//   rd_req        : consumer pop request
//   flush         : single-cycle flush request
//   rd_en         : pop accepted; drives the read counter enable
//   rd_addr       : RAM read address (binary read pointer LSBs)
//   flush_ptr_bin : binary synced write pointer; counter loads it on flush
//   empty         : FIFO empty (combinational)
//   almost_empty  : level <= AE_THRESH (registered)
//   rd_level      : fill level (registered)
//   ptr_err       : sticky, level ever exceeded the FIFO depth
// ----------------------------------------------------------------------------
module gen_fifo_rd_status
    import gen_fifo_rd_status_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int AE_THRESH   = 1,
    localparam int PTR_WIDTH   = ptr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PTR_WIDTH-1:0]  wr_ptr_gray,
    input  logic [PTR_WIDTH-1:0]  rd_ptr_gray,
    input  logic                  rd_req,
    input  logic                  flush,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PTR_WIDTH-1:0]  flush_ptr_bin,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH-1:0]  rd_level,
    output logic                  ptr_err
);

    localparam logic [PTR_WIDTH-1:0] DEPTH    = PTR_WIDTH'(1) << ADDR_WIDTH;
    localparam logic [PTR_WIDTH-1:0] AE_LIMIT = PTR_WIDTH'(AE_THRESH);

    logic [PTR_WIDTH-1:0] wr_sync;
    logic [PTR_WIDTH-1:0] wr_bin;
    logic [PTR_WIDTH-1:0] rd_bin;
    logic [PTR_WIDTH-1:0] level_c;
    logic                 ae_c;

    // ---- stage p0: write pointer crosses into the read clock (gray only) ----
    gen_ptr_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (wr_ptr_gray),
        .q       (wr_sync)
    );

    // ---- stage p1: combinational status from flop outputs ----
    assign wr_bin  = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(wr_sync)));
    assign rd_bin  = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(rd_ptr_gray)));

    // Modular subtraction absorbs the wrap of the extra pointer bit.
    assign level_c = wr_bin - rd_bin;
    assign ae_c    = (level_c <= AE_LIMIT);

    // Comparing gray codes directly avoids waiting on the conversion chain.
    assign empty         = (wr_sync == rd_ptr_gray);
    assign rd_en         = rd_req & ~empty & ~flush;
    assign rd_addr       = rd_bin[ADDR_WIDTH-1:0];
    assign flush_ptr_bin = wr_bin;

    // ---- stage p2: registered level / almost_empty / error ----
    // During flush the counter jumps to the write pointer, so the level after
    // that edge is zero regardless of what level_c shows this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
            ptr_err      <= 1'b0;
        end else begin
            if (flush) begin
                rd_level     <= '0;
                almost_empty <= 1'b1;
            end else begin
                rd_level     <= level_c;
                almost_empty <= ae_c;
            end
            if (level_c > DEPTH) begin
                ptr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gen_fifo_rd_status.sv
module tb_gen_fifo_rd_status;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
    logic       rd_req;
    logic       flush;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [4:0] flush_ptr_bin;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       ptr_err;

    // Read-counter stand-in: loads a preset, loads flush_ptr_bin on flush,
    // increments on rd_en.
    logic [4:0] rd_cnt;
    logic       preset_en;
    logic [4:0] preset_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gen_fifo_rd_status #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_ptr_gray   (wr_ptr_gray),
        .rd_ptr_gray   (rd_ptr_gray),
        .rd_req        (rd_req),
        .flush         (flush),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .flush_ptr_bin (flush_ptr_bin),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .ptr_err       (ptr_err)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       rd_cnt <= 5'd0;
        else if (preset_en) rd_cnt <= preset_val;
        else if (flush)     rd_cnt <= flush_ptr_bin;
        else if (rd_en)     rd_cnt <= rd_cnt + 5'd1;
    end

    assign rd_ptr_gray = rd_cnt ^ (rd_cnt >> 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; returns on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rd(input logic [4:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        step();
        preset_en  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        wr_ptr_gray = 5'd0;
        rd_req      = 1'b0;
        flush       = 1'b0;
        preset_en   = 1'b0;
        preset_val  = 5'd0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] wr_gray;
        logic [4:0] rd_bin;
        logic [4:0] level;
        logic       empty;
        logic       ae;
        logic [3:0] addr;
        logic [4:0] fpb;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [3:0] pulse_addr;

        //            wr_gray   rd  lvl  emp ae addr fpb
        vecs[0] = '{5'b00000,  0,   0,  1,  1,  0,  0};
        vecs[1] = '{5'b00001,  0,   1,  0,  1,  0,  1};
        vecs[2] = '{5'b00011,  0,   2,  0,  0,  0,  2};
        vecs[3] = '{5'b11000,  0,  16,  0,  0,  0, 16};
        vecs[4] = '{5'b00100,  5,   2,  0,  0,  5,  7};
        vecs[5] = '{5'b00010, 19,  16,  0,  0,  3,  3};
        vecs[6] = '{5'b01010, 12,   0,  1,  1, 12, 12};

        // Test 1: reset held with a pending request and nonzero write pointer
        reset_n     = 1'b0;
        rd_req      = 1'b1;
        flush       = 1'b0;
        preset_en   = 1'b0;
        preset_val  = 5'd0;
        wr_ptr_gray = 5'b00011;
        step();
        step();
        check("t1_rst_empty", 32'(empty), 1);
        check("t1_rst_rd_en", 32'(rd_en), 0);
        check("t1_rst_level", 32'(rd_level), 0);
        check("t1_rst_fpb", 32'(flush_ptr_bin), 0);
        check("t1_rst_ae", 32'(almost_empty), 1);
        check("t1_rst_err", 32'(ptr_err), 0);
        reset_n = 1'b1;
        step();
        check("t1_edge1_empty", 32'(empty), 1);
        step();
        check("t1_edge2_empty", 32'(empty), 0);
        check("t1_edge2_rd_en", 32'(rd_en), 1);
        step();
        check("t1_edge3_level", 32'(rd_level), 2);
        rd_req = 1'b0;

        // Test 2: single entry, request held -> exactly one pop
        do_reset();
        wr_ptr_gray = 5'b00001;
        rd_req      = 1'b1;
        pulses      = 0;
        pulse_addr  = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (rd_en) begin
                pulses++;
                pulse_addr = rd_addr;
            end
            step();
        end
        check("t2_pulses", 32'(pulses), 1);
        check("t2_addr", 32'(pulse_addr), 0);
        check("t2_empty", 32'(empty), 1);
        check("t2_ae", 32'(almost_empty), 1);
        rd_req = 1'b0;

        // Table: steady-state status for assorted pointer pairs
        for (int v = 0; v < 7; v++) begin
            do_reset();
            wr_ptr_gray = vecs[v].wr_gray;
            step();
            step();
            set_rd(vecs[v].rd_bin);
            step();
            check($sformatf("vec%0d_level", v), 32'(rd_level), 32'(vecs[v].level));
            check($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].empty));
            check($sformatf("vec%0d_ae", v), 32'(almost_empty), 32'(vecs[v].ae));
            check($sformatf("vec%0d_addr", v), 32'(rd_addr), 32'(vecs[v].addr));
            check($sformatf("vec%0d_fpb", v), 32'(flush_ptr_bin), 32'(vecs[v].fpb));
            check($sformatf("vec%0d_err", v), 32'(ptr_err), 0);
        end

        // Test 3: write pointer wraps 31 -> 0 with read pointer at 30
        do_reset();
        set_rd(5'd30);
        wr_ptr_gray = 5'b10000;
        step();
        step();
        step();
        check("t3_level_pre", 32'(rd_level), 1);
        check("t3_ae_pre", 32'(almost_empty), 1);
        wr_ptr_gray = 5'b00000;
        step();
        step();
        step();
        check("t3_level_post", 32'(rd_level), 2);
        check("t3_ae_post", 32'(almost_empty), 0);
        check("t3_err", 32'(ptr_err), 0);

        // Test 4: flush at level 5 with a simultaneous request
        do_reset();
        wr_ptr_gray = 5'b01101;
        step();
        step();
        set_rd(5'd4);
        step();
        check("t4_level", 32'(rd_level), 5);
        check("t4_ae", 32'(almost_empty), 0);
        flush  = 1'b1;
        rd_req = 1'b1;
        #1;
        check("t4_flush_rd_en", 32'(rd_en), 0);
        check("t4_flush_fpb", 32'(flush_ptr_bin), 9);
        step();
        flush = 1'b0;
        #1;
        check("t4_after_rd_gray", 32'(rd_ptr_gray), 32'(5'b01101));
        check("t4_after_empty", 32'(empty), 1);
        check("t4_after_rd_en", 32'(rd_en), 0);
        check("t4_after_level", 32'(rd_level), 0);
        check("t4_after_ae", 32'(almost_empty), 1);
        step();
        check("t4_next_level", 32'(rd_level), 0);
        rd_req = 1'b0;

        // Test 5: overfull level sets sticky error
        do_reset();
        wr_ptr_gray = 5'b11110;
        step();
        step();
        step();
        check("t5_level", 32'(rd_level), 20);
        check("t5_err_set", 32'(ptr_err), 1);
        wr_ptr_gray = 5'b00000;
        step();
        step();
        step();
        check("t5_level_recov", 32'(rd_level), 0);
        check("t5_err_sticky", 32'(ptr_err), 1);
        reset_n = 1'b0;
        #1;
        check("t5_err_reset", 32'(ptr_err), 0);
        step();
        reset_n = 1'b1;

        // Test 6: asynchronous reset in the middle of a pop stream
        do_reset();
        wr_ptr_gray = 5'b00010;
        rd_req      = 1'b1;
        step();
        step();
        step();
        check("t6_popping", 32'(rd_en), 1);
        check("t6_level", 32'(rd_level), 3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_rd_en", 32'(rd_en), 0);
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_level", 32'(rd_level), 0);
        check("t6_rst_ae", 32'(almost_empty), 1);
        check("t6_rst_err", 32'(ptr_err), 0);
        check("t6_rst_fpb", 32'(flush_ptr_bin), 0);
        @(posedge clk);
        #1;
        check("t6_rst_edge_rd_en", 32'(rd_en), 0);
        @(negedge clk);
        rd_req  = 1'b0;
        reset_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_fifo_rd_status.md
Name: gen_fifo_rd_status

Overview:
Read-domain status stage of the XSPI AHB slave async FIFO, sitting directly downstream of the read-side gray pointer counter.
- Synchronises the write-domain gray pointer into the read clock.
- Converts both pointers to binary and generates empty, almost-empty, fill level and the pop enable that drives the counter's enable input.
- On flush, supplies the synchronised write pointer (binary) that the counter loads as wr_addr_bin, so the FIFO is emptied.

Parameters:
ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH.
PTR_WIDTH, ADDR_WIDTH+1, pointer width (extra wrap bit); derived, not overridden.
SYNC_STAGES, 2, flops in write-pointer synchroniser (min 2).
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH.

Ports:
clk  in  1  read-domain clock.
reset_n  in  1  asynchronous active-low reset.
wr_ptr_gray  in  PTR_WIDTH  write pointer, gray, asynchronous to clk.
rd_ptr_gray  in  PTR_WIDTH  local read pointer, gray, from read counter count.
rd_req  in  1  consumer requests a pop.
flush  in  1  single-cycle FIFO flush request.
rd_en  out  1  pop accepted; drives read counter enable.
rd_addr  out  ADDR_WIDTH  RAM read address (binary rd pointer LSBs).
flush_ptr_bin  out  PTR_WIDTH  binary synced write pointer; drives counter wr_addr_bin.
empty  out  1  FIFO empty.
almost_empty  out  1  level <= AE_THRESH (registered).
rd_level  out  PTR_WIDTH  fill level (registered).
ptr_err  out  1  sticky: level exceeded depth.

Behaviour:
- Reset (reset_n low, async): all sync flops = 0, rd_level = 0, almost_empty = 1, ptr_err = 0.
  - Combinational outputs follow: empty = 1, rd_en = 0, flush_ptr_bin = 0.
  - Exit is synchronous to the first clk edge with reset_n high.
- Synchroniser: wr_ptr_gray passes through SYNC_STAGES flops; wr_sync = last stage. Only the gray vector crosses; no binary crosses domains.
- Gray-to-binary conversion: bit i = XOR of gray bits [PTR_WIDTH-1:i], applied to wr_sync (wr_bin) and rd_ptr_gray (rd_bin).
- level_c = (wr_bin - rd_bin) mod 2**PTR_WIDTH, PTR_WIDTH-bit unsigned; wrap of the MSB handled by modular subtraction.
- empty = (wr_sync == rd_ptr_gray), combinational from flop outputs only.
- rd_en = rd_req & ~empty & ~flush (combinational). The counter advances on that edge; empty re-evaluates from the new rd_ptr_gray next cycle, so back-to-back pops are allowed.
- rd_addr = rd_bin[ADDR_WIDTH-1:0].
- flush_ptr_bin = wr_bin at all times.
  - The counter loads it when flush = 1; rd_en is forced 0 during flush.
  - Cycle after flush: rd_ptr_gray == wr_sync, so empty = 1 unless wr_sync moved that edge.
- Registered status, updated every clk:
  - rd_level <= level_c
  - almost_empty <= (level_c <= AE_THRESH)
  - Both lag empty by one cycle; both are forced to 0 / 1 respectively on the cycle after flush.
- ptr_err: set when level_c > 2**ADDR_WIDTH; sticky until reset_n.
- Latency:
  - A write-pointer change is visible on empty SYNC_STAGES edges after it settles.
  - It is visible on rd_level one edge later.
- Simultaneous rd_req and flush: flush wins; no pop.
- rd_req while empty: ignored; no error.

Decomposition:
- Shared package/include: gray2bin function (parameterised width) and PTR_WIDTH derivation, reused by the write-side full-flag block.
- One sub-module: gen_ptr_sync (SYNC_STAGES-deep multi-bit flop chain, async active-low reset). Everything else is inline.

Test Plan:
(ADDR_WIDTH=4, SYNC_STAGES=2, AE_THRESH=1.)
1. Reset held with rd_req=1, wr_ptr_gray=5'b00011 -> empty=1, rd_en=0, rd_level=0, flush_ptr_bin=0; after release, empty=0 two edges later, rd_level=2 on the following edge.
2. wr_ptr_gray 0->5'b00001, counter in loop, rd_req=1 held -> exactly one rd_en pulse, rd_addr=0, then empty=1, almost_empty=1.
3. Wrap: rd pointer bin 30, write pointer bin 31 -> 0 (gray 10000 -> 00000) -> rd_level 1 -> 2, almost_empty 1 -> 0, ptr_err=0.
4. Level 5 (wr bin 9, rd bin 4), flush=1 with rd_req=1 -> rd_en=0, flush_ptr_bin=9; next cycle rd_ptr_gray=gray(9), empty=1; following cycle rd_level=0.
5. wr bin 20, rd bin 0 -> rd_level=20, ptr_err=1; stays 1 after pointers recover; clears only on reset_n.
6. reset_n pulsed low mid-stream between clk edges -> all outputs take reset values immediately; no rd_en glitch on the reset edge.
